// File: rtl/ahb_dma_master_if.sv
// Purpose: bundles the AHB-Lite initiator signals and the AES block handshake of the DMA master.
// Latency: none, wiring only.
// Backpressure: hready stalls the bus side; blk_out_ready / blk_in_valid pace the core side.
// Ports (master view): haddr/htrans/hwrite/hsize/hwdata out, hrdata/hready/hresp in,
//                      blk_out/blk_out_valid/blk_in_ready out, blk_out_ready/blk_in/blk_in_valid in.
interface ahb_dma_master_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] haddr;
    logic [1:0]        htrans;
    logic              hwrite;
    logic [2:0]        hsize;
    logic [31:0]       hwdata;
    logic [31:0]       hrdata;
    logic              hready;
    logic              hresp;
    logic [127:0]      blk_out;
    logic              blk_out_valid;
    logic              blk_out_ready;
    logic [127:0]      blk_in;
    logic              blk_in_valid;
    logic              blk_in_ready;

    modport master (
        output haddr, htrans, hwrite, hsize, hwdata,
        input  hrdata, hready, hresp,
        output blk_out, blk_out_valid, blk_in_ready,
        input  blk_out_ready, blk_in, blk_in_valid
    );

    modport slave (
        input  haddr, htrans, hwrite, hsize, hwdata,
        output hrdata, hready, hresp,
        input  blk_out, blk_out_valid, blk_in_ready,
        output blk_out_ready, blk_in, blk_in_valid
    );
endinterface

// File: rtl/ahb_dma_master.sv
// Purpose: AHB-Lite DMA initiator; reads 128-bit blocks as four single word reads, hands them to the AES core, writes the result back.
// Latency: 2 cycles per unstalled word (8 read + 8 write cycles per block) plus core handshake; done pulses the cycle after DONE.
// Backpressure: hready=0 holds every address/data-phase output; blk_out held until blk_out_ready; result waited for on blk_in_valid.
// Ports: hclk/hresetn clock and async active-low reset; start, data_read_loc, data_write_loc, size_data request inputs;
//        busy, done, err status; bus = AHB master signals plus AES block handshake (ahb_dma_master_if.master).
module ahb_dma_master #(
    parameter int ADDR_W    = 32,
    parameter int BLK_WORDS = 4
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              start,
    input  logic [ADDR_W-1:0] data_read_loc,
    input  logic [ADDR_W-1:0] data_write_loc,
    input  logic [31:0]       size_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    ahb_dma_master_if.master  bus
);
    localparam int         BLK_BITS = 32 * BLK_WORDS;
    localparam logic [1:0] LAST_IDX = 2'(BLK_WORDS - 1);
    localparam logic [1:0] HTRANS_IDLE    = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ADDR,
        S_RD_DATA,
        S_PUSH,
        S_WAIT_RES,
        S_WR_ADDR,
        S_WR_DATA,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [27:0]         r_blk_left;
    logic [1:0]          r_idx;
    logic [BLK_BITS-1:0] r_rd_blk;
    logic [BLK_BITS-1:0] r_wr_blk;
    logic [31:0]         r_hwdata;
    logic                r_busy;
    logic                r_done;
    logic                r_err;

    logic                w_accept;
    logic                w_rd_beat;
    logic                w_wr_beat;
    logic                w_res_take;
    logic                w_wr_load;
    logic                w_bus_err;
    logic                w_last_word;

    // Length granularity is one block; the sub-block byte count is dropped.
    logic                w_unused_size_lsb;
    assign w_unused_size_lsb = ^size_data[3:0];

    assign w_last_word = (r_idx == LAST_IDX);

    // Next-state and per-cycle strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_rd_beat   = 1'b0;
        w_wr_beat   = 1'b0;
        w_res_take  = 1'b0;
        w_wr_load   = 1'b0;
        w_bus_err   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (size_data[31:4] == 28'd0) ? S_DONE : S_RD_ADDR;
                end
            end
            S_RD_ADDR: begin
                if (bus.hready) w_state_nxt = S_RD_DATA;
            end
            S_RD_DATA: begin
                if (bus.hresp) begin
                    w_bus_err   = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (bus.hready) begin
                    w_rd_beat   = 1'b1;
                    w_state_nxt = w_last_word ? S_PUSH : S_RD_ADDR;
                end
            end
            S_PUSH: begin
                if (bus.blk_out_ready) w_state_nxt = S_WAIT_RES;
            end
            S_WAIT_RES: begin
                if (bus.blk_in_valid) begin
                    w_res_take  = 1'b1;
                    w_state_nxt = S_WR_ADDR;
                end
            end
            S_WR_ADDR: begin
                if (bus.hready) begin
                    w_wr_load   = 1'b1;
                    w_state_nxt = S_WR_DATA;
                end
            end
            S_WR_DATA: begin
                if (bus.hresp) begin
                    w_bus_err   = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (bus.hready) begin
                    w_wr_beat = 1'b1;
                    if (!w_last_word)
                        w_state_nxt = S_WR_ADDR;
                    else if (r_blk_left != 28'd1)
                        w_state_nxt = S_RD_ADDR;
                    else
                        w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Datapath. Read words shift in from the bottom so the lowest address
    // ends in the top slot; write words shift out of the top for the same order.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_blk_left <= '0;
            r_idx      <= '0;
            r_rd_blk   <= '0;
            r_wr_blk   <= '0;
            r_hwdata   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= (r_state == S_DONE);
            if (r_state == S_DONE) r_busy <= 1'b0;

            if (w_accept) begin
                r_rd_ptr   <= data_read_loc;
                r_wr_ptr   <= data_write_loc;
                r_blk_left <= size_data[31:4];
                r_idx      <= '0;
                r_busy     <= 1'b1;
                r_err      <= 1'b0;
            end

            if (w_bus_err) r_err <= 1'b1;

            if (w_rd_beat) begin
                r_rd_blk <= {r_rd_blk[BLK_BITS-33:0], bus.hrdata};
                r_rd_ptr <= r_rd_ptr + ADDR_W'(4);
                r_idx    <= w_last_word ? 2'd0 : r_idx + 2'd1;
            end

            if (w_res_take) r_wr_blk <= bus.blk_in;

            // hwdata is loaded at the end of the address phase so it is
            // already valid on the first cycle of the data phase.
            if (w_wr_load) r_hwdata <= r_wr_blk[BLK_BITS-1 -: 32];

            if (w_wr_beat) begin
                r_wr_blk <= {r_wr_blk[BLK_BITS-33:0], 32'd0};
                r_wr_ptr <= r_wr_ptr + ADDR_W'(4);
                r_idx    <= w_last_word ? 2'd0 : r_idx + 2'd1;
                if (w_last_word) r_blk_left <= r_blk_left - 28'd1;
            end
        end
    end

    // Bus outputs decode straight from the state register, so an async
    // reset drops htrans to IDLE in the same cycle.
    assign bus.htrans        = (r_state == S_RD_ADDR || r_state == S_WR_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign bus.haddr         = (r_state == S_WR_ADDR || r_state == S_WR_DATA) ? r_wr_ptr : r_rd_ptr;
    assign bus.hwrite        = (r_state == S_WR_ADDR || r_state == S_WR_DATA);
    assign bus.hsize         = 3'b010;
    assign bus.hwdata        = r_hwdata;
    assign bus.blk_out       = r_rd_blk;
    assign bus.blk_out_valid = (r_state == S_PUSH);
    assign bus.blk_in_ready  = (r_state == S_WAIT_RES);

    assign busy = r_busy;
    assign done = r_done;
    assign err  = r_err;
endmodule

// File: tb/tb_ahb_dma_master.sv
// Purpose: self-checking bench for ahb_dma_master with an AHB slave, an AES core stand-in and a transfer-level reference model.
// Latency: n/a.
// Backpressure: slave inserts configurable or random wait states; core accepts/returns blocks after random delays.
module tb_ahb_dma_master;
    logic        hclk;
    logic        hresetn;
    logic        start;
    logic [31:0] data_read_loc;
    logic [31:0] data_write_loc;
    logic [31:0] size_data;
    logic        busy;
    logic        done;
    logic        err;

    ahb_dma_master_if #(.ADDR_W(32)) bus ();

    ahb_dma_master #(.ADDR_W(32), .BLK_WORDS(4)) dut (
        .hclk           (hclk),
        .hresetn        (hresetn),
        .start          (start),
        .data_read_loc  (data_read_loc),
        .data_write_loc (data_write_loc),
        .size_data      (size_data),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .bus            (bus)
    );

    initial begin
        hclk = 1'b0;
        forever #5 hclk = ~hclk;
    end

    int checks = 0;
    int errors = 0;

    logic [31:0]  mem [bit [31:0]];
    logic [31:0]  rd_log[$];
    logic [63:0]  wr_log[$];
    logic [127:0] push_log[$];
    logic [31:0]  exp_rd[$];
    logic [63:0]  exp_wr[$];
    logic [127:0] exp_push[$];

    int wait_cfg = 0;
    int err_at = 0;
    int rd_n = 0;
    int stall_viol = 0;
    int core_viol = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int busy_cyc = 0;
    int nonseq_cyc = 0;
    int cyc = 0;
    int start_cyc = 0;
    logic [127:0] core_key = '0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge hclk) cyc <= cyc + 1;

    always @(negedge hclk) begin
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (busy === 1'b1) busy_cyc++;
        if (bus.htrans === 2'b10) nonseq_cyc++;
    end

    // AHB slave: one outstanding transfer, wait states per phase.
    bit          pend;
    int          cnt, tgt;
    logic [31:0] ph_addr, ph_wdata;
    logic        ph_write;
    always @(negedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            pend = 0; cnt = 0;
            bus.hready = 1'b1; bus.hresp = 1'b0; bus.hrdata = '0;
        end else begin
            bus.hresp = 1'b0;
            if (!pend && bus.htrans === 2'b10) begin
                if (cnt == 0) begin
                    tgt = (wait_cfg < 0) ? int'($urandom_range(0, 2)) : wait_cfg;
                    ph_addr = bus.haddr; ph_write = bus.hwrite;
                end else if (bus.haddr !== ph_addr || bus.hwrite !== ph_write) begin
                    stall_viol++;
                end
                if (cnt < tgt) begin
                    bus.hready = 1'b0; cnt++;
                end else begin
                    bus.hready = 1'b1; cnt = 0; pend = 1;
                    if (!ph_write) rd_log.push_back(ph_addr);
                end
            end else if (pend) begin
                if (cnt == 0) begin
                    tgt = (wait_cfg < 0) ? int'($urandom_range(0, 2)) : wait_cfg;
                    ph_wdata = bus.hwdata;
                end else if (bus.hwdata !== ph_wdata) begin
                    stall_viol++;
                end
                if (bus.htrans !== 2'b00) stall_viol++;
                if (cnt < tgt) begin
                    bus.hready = 1'b0; cnt++;
                end else begin
                    bus.hready = 1'b1; cnt = 0; pend = 0;
                    if (ph_write) begin
                        wr_log.push_back({ph_addr, bus.hwdata});
                        mem[ph_addr] = bus.hwdata;
                    end else begin
                        rd_n++;
                        bus.hrdata = mem[ph_addr];
                        if (rd_n == err_at) bus.hresp = 1'b1;
                    end
                end
            end else begin
                if (cnt != 0) stall_viol++;
                cnt = 0;
                bus.hready = 1'b1;
            end
        end
    end

    // AES core stand-in: returns blk_out XOR core_key.
    bit          out_seen, in_seen;
    int          cdly_o, cdly_i;
    logic [127:0] held_out;
    always @(negedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            bus.blk_out_ready = 1'b0; bus.blk_in_valid = 1'b0; bus.blk_in = '0;
            out_seen = 0; in_seen = 0;
        end else begin
            bus.blk_out_ready = 1'b0;
            bus.blk_in_valid  = 1'b0;
            if (bus.blk_out_valid === 1'b1) begin
                if (!out_seen) begin
                    out_seen = 1; held_out = bus.blk_out; cdly_o = int'($urandom_range(0, 2));
                end else if (bus.blk_out !== held_out) begin
                    core_viol++;
                end
                if (cdly_o == 0) begin
                    bus.blk_out_ready = 1'b1; push_log.push_back(bus.blk_out); out_seen = 0;
                end else begin
                    cdly_o--;
                end
            end
            if (bus.blk_in_ready === 1'b1) begin
                if (!in_seen) begin
                    in_seen = 1; cdly_i = int'($urandom_range(0, 2));
                end
                if (cdly_i == 0 && push_log.size() > 0) begin
                    bus.blk_in_valid = 1'b1; bus.blk_in = push_log[$] ^ core_key; in_seen = 0;
                end else if (cdly_i > 0) begin
                    cdly_i--;
                end
            end
        end
    end

    task automatic clear_logs();
        rd_log.delete(); wr_log.delete(); push_log.delete();
        rd_n = 0; stall_viol = 0; core_viol = 0;
        done_cnt = 0; busy_cyc = 0; nonseq_cyc = 0;
    endtask

    // Reference: a transfer of n blocks reads base+4i in order, forms each block
    // with the lowest address on top, and writes block^key word by word.
    task automatic build_expect(input logic [31:0] rd, input logic [31:0] wr, input logic [31:0] size,
                                input int e_at, input bit fill);
        int unsigned nblk;
        logic [127:0] blk, res;
        logic [31:0] a;
        exp_rd.delete(); exp_wr.delete(); exp_push.delete();
        nblk = size / 16;
        for (int b = 0; b < int'(nblk); b++) begin
            blk = '0;
            for (int k = 0; k < 4; k++) begin
                a = rd + 32'(16 * b + 4 * k);
                if (fill) mem[a] = $urandom;
                exp_rd.push_back(a);
                blk = {blk[95:0], mem[a]};
            end
            exp_push.push_back(blk);
            res = blk ^ core_key;
            for (int k = 0; k < 4; k++) begin
                exp_wr.push_back({wr + 32'(16 * b + 4 * k), res[127:96]});
                res = res << 32;
            end
        end
        if (e_at > 0) begin
            while (exp_rd.size() > e_at) void'(exp_rd.pop_back());
            exp_push.delete();
            exp_wr.delete();
        end
    endtask

    task automatic run_xfer(input string tag, input logic [31:0] rd, input logic [31:0] wr,
                            input logic [31:0] size, input int waits, input int e_at,
                            input logic [127:0] key, input bit fill, input bit dup);
        bit got_done;
        core_key = key; wait_cfg = waits; err_at = e_at;
        build_expect(rd, wr, size, e_at, fill);
        clear_logs();
        @(negedge hclk);
        start = 1'b1; data_read_loc = rd; data_write_loc = wr; size_data = size;
        start_cyc = cyc;
        @(negedge hclk);
        start = 1'b0;
        data_read_loc = $urandom; data_write_loc = $urandom; size_data = $urandom;
        check({tag, "_err_clr"}, err, 1'b0);
        check({tag, "_busy"}, busy, 1'b1);
        if (dup) begin
            repeat (3) @(negedge hclk);
            start = 1'b1;
            @(negedge hclk);
            start = 1'b0;
        end
        got_done = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge hclk);
            if (done_cnt > 0) begin
                got_done = 1;
                break;
            end
        end
        check({tag, "_done_seen"}, got_done, 1'b1);
        repeat (4) @(negedge hclk);
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_err"}, err, (e_at > 0));
        check({tag, "_busy_end"}, busy, 1'b0);
        check({tag, "_nrd"}, rd_log.size(), exp_rd.size());
        for (int i = 0; i < exp_rd.size() && i < rd_log.size(); i++)
            check($sformatf("%s_rd%0d", tag, i), rd_log[i], exp_rd[i]);
        check({tag, "_npush"}, push_log.size(), exp_push.size());
        for (int i = 0; i < exp_push.size() && i < push_log.size(); i++)
            check($sformatf("%s_blk%0d", tag, i), push_log[i], exp_push[i]);
        check({tag, "_nwr"}, wr_log.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++)
            check($sformatf("%s_wr%0d", tag, i), wr_log[i], exp_wr[i]);
        check({tag, "_stall"}, stall_viol, 0);
        check({tag, "_blkhold"}, core_viol, 0);
    endtask

    initial begin
        bit found;
        int ns0;
        hresetn = 1'b0; start = 1'b0;
        data_read_loc = '0; data_write_loc = '0; size_data = '0;
        repeat (3) @(negedge hclk);
        check("rst_htrans", bus.htrans, 2'b00);
        check("rst_haddr", bus.haddr, 32'h0);
        check("rst_hwrite", bus.hwrite, 1'b0);
        check("rst_hwdata", bus.hwdata, 32'h0);
        check("rst_hsize", bus.hsize, 3'b010);
        check("rst_blk_out", bus.blk_out, 128'h0);
        check("rst_hs", {bus.blk_out_valid, bus.blk_in_ready}, 2'b00);
        check("rst_status", {busy, done, err}, 3'b000);
        hresetn = 1'b1;
        @(negedge hclk);

        // Single block, zero-wait slave.
        mem[32'h100] = 32'h11111111; mem[32'h104] = 32'h22222222;
        mem[32'h108] = 32'h33333333; mem[32'h10C] = 32'h44444444;
        run_xfer("single", 32'h100, 32'h200, 32'd16, 0, 0, {4{32'hFFFFFFFF}}, 1'b0, 1'b0);
        check("single_blk_lit", push_log[0], 128'h11111111_22222222_33333333_44444444);
        check("single_wr0_lit", wr_log[0], {32'h200, 32'hEEEEEEEE});
        check("single_wr3_lit", wr_log[3], {32'h20C, 32'hBBBBBBBB});

        // Two blocks with two wait states on every phase.
        run_xfer("wait", 32'h300, 32'h400, 32'd32, 2, 0, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0);

        // Zero-block lengths.
        run_xfer("size0", 32'h300, 32'h400, 32'd0, 0, 0, '0, 1'b1, 1'b0);
        check("size0_nonseq", nonseq_cyc, 0);
        check("size0_busy_cyc", busy_cyc, 1);
        check("size0_done_lat", done_cyc - start_cyc, 2);
        run_xfer("size15", 32'h300, 32'h400, 32'd15, 0, 0, '0, 1'b1, 1'b0);
        check("size15_nonseq", nonseq_cyc, 0);
        check("size15_busy_cyc", busy_cyc, 1);
        check("size15_done_lat", done_cyc - start_cyc, 2);

        // Bus error on the third read data phase.
        run_xfer("rderr", 32'h500, 32'h600, 32'd16, 0, 3, {4{32'h5A5A5A5A}}, 1'b1, 1'b0);

        // Address wrap plus an ignored second start; also clears the sticky error.
        run_xfer("wrap", 32'hFFFFFFF8, 32'h1000, 32'd16, 1, 0, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b1);
        check("wrap_rd2", exp_rd[2], 32'h00000000);

        // Reset during a write address phase.
        core_key = {4{32'h0F0F0F0F}}; wait_cfg = 1; err_at = 0;
        for (int i = 0; i < 8; i++) mem[32'h700 + 32'(4 * i)] = $urandom;
        clear_logs();
        @(negedge hclk);
        start = 1'b1; data_read_loc = 32'h700; data_write_loc = 32'h800; size_data = 32'd32;
        @(negedge hclk);
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge hclk);
            if (bus.htrans === 2'b10 && bus.hwrite === 1'b1) begin
                found = 1;
                break;
            end
        end
        check("rstmid_reach_wr", found, 1'b1);
        #2 hresetn = 1'b0;
        #1;
        check("rstmid_htrans", bus.htrans, 2'b00);
        check("rstmid_haddr", bus.haddr, 32'h0);
        check("rstmid_hwrite", bus.hwrite, 1'b0);
        check("rstmid_hwdata", bus.hwdata, 32'h0);
        check("rstmid_blk_out", bus.blk_out, 128'h0);
        check("rstmid_status", {busy, done, err, bus.blk_out_valid, bus.blk_in_ready}, 5'b0);
        ns0 = nonseq_cyc;
        repeat (4) @(negedge hclk);
        check("rstmid_no_bus", nonseq_cyc, ns0);
        check("rstmid_no_done", done_cnt, 0);
        hresetn = 1'b1;
        @(negedge hclk);

        // Randomized transfers with random wait states and core delays.
        for (int r = 0; r < 4; r++) begin
            run_xfer($sformatf("rnd%0d", r),
                     32'h0001_0000 + 32'($urandom_range(0, 255) * 16),
                     32'h0008_0000 + 32'($urandom_range(0, 255) * 16),
                     32'($urandom_range(0, 4) * 16 + $urandom_range(0, 15)),
                     -1, 0, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ahb_dma_master.md
Name: ahb_dma_master

Overview:
- AHB-Lite initiator that moves data for the AES accelerator.
- It is the bus-master counterpart of the register-file slave, which supplies data_read_loc, data_write_loc and size_data.
- On start it fetches 128-bit blocks from memory as four 32-bit single reads, hands each block to the AES core, and writes the returned block back as four 32-bit single writes.
- It repeats until size_data bytes have been processed, then reports done.

Parameters:
- ADDR_W, 32, AHB address width and width of the pointer registers.
- BLK_WORDS, 4, 32-bit words per AES block (fixed at 4; the parameter documents intent only).

Ports:
- hclk  in  1  bus clock; all logic on rising edge.
- hresetn  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request pulse; ignored while busy=1.
- data_read_loc  in  32  source byte address; sampled on accepted start.
- data_write_loc  in  32  destination byte address; sampled on accepted start.
- size_data  in  32  transfer length in bytes; sampled on accepted start.
- haddr  out  32  AHB address.
- htrans  out  2  2'b10 NONSEQ in address phase, otherwise 2'b00 IDLE.
- hwrite  out  1  1 = write transfer.
- hsize  out  3  constant 3'b010 (word).
- hwdata  out  32  write data, valid in the write data phase.
- hrdata  in  32  read data.
- hready  in  1  transfer-complete / wait-state indication from the slave.
- hresp  in  1  0 = OKAY, 1 = ERROR.
- blk_out  out  128  plaintext block to the AES core.
- blk_out_valid  out  1  blk_out holds a block.
- blk_out_ready  in  1  core accepts blk_out.
- blk_in  in  128  processed block from the core.
- blk_in_valid  in  1  blk_in holds a block.
- blk_in_ready  out  1  DMA accepts blk_in.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse at end of transfer.
- err  out  1  sticky error; cleared on next accepted start.

Behaviour:
- Reset (hresetn=0, asynchronous):
  - State IDLE.
  - haddr=0, htrans=IDLE, hwrite=0, hwdata=0.
  - blk_out=0, blk_out_valid=0, blk_in_ready=0.
  - busy=0, done=0, err=0.
  - Pointers, block count and word index all 0.
  - Reset asserted mid-transfer aborts immediately; no further bus activity.
- Block count: nblk = size_data[31:4]; bits [3:0] are ignored. nblk=0 completes at once: start -> DONE -> done pulse, with no bus transfer.
- Word order: word k sits at address base + 4k and maps to block bits [127-32k : 96-32k]. The lowest address holds [127:96].
- Pointers advance +4 per completed word and wrap modulo 2^32.
- State machine, states IDLE, RD_ADDR, RD_DATA, PUSH, WAIT_RES, WR_ADDR, WR_DATA, DONE:
  - IDLE: start=1 latches the inputs, sets busy=1, clears err, word index=0, then goes to RD_ADDR (or DONE if nblk=0).
  - RD_ADDR: haddr=rd_ptr, htrans=NONSEQ, hwrite=0.
    - hready=1: go to RD_DATA.
    - hready=0: hold all address-phase outputs.
  - RD_DATA: htrans=IDLE.
    - hready=1 and hresp=0: capture hrdata into word slot, rd_ptr += 4. If index=3, index=0 and go to PUSH; else index+1 and go to RD_ADDR.
    - hresp=1: err=1, go to DONE.
  - PUSH: blk_out_valid=1.
    - blk_out_ready=1: go to WAIT_RES.
    - blk_out and blk_out_valid stay stable until accepted.
  - WAIT_RES: blk_in_ready=1.
    - blk_in_valid=1: latch blk_in and go to WR_ADDR.
  - WR_ADDR: haddr=wr_ptr, htrans=NONSEQ, hwrite=1.
    - hready=1: go to WR_DATA.
  - WR_DATA: htrans=IDLE, hwdata=current word.
    - hready=1 and hresp=0: wr_ptr += 4. If index<3, index+1 and go to WR_ADDR. If index=3, decrement blocks remaining; go to RD_ADDR if any remain, else DONE.
    - hresp=1: err=1, go to DONE.
  - DONE: done=1 for one cycle, busy=0, then IDLE.
- Bus timing: non-pipelined, one outstanding transfer. Minimum cost is 2 cycles per word, so an unstalled block takes 8 read + 8 write cycles plus the core handshake.
- hwdata holds its last value outside WR_DATA. hsize is always 3'b010.
- A start asserted while busy=1 is ignored. Inputs changed mid-transfer have no effect.

Test Plan:
- Single block, zero-wait slave:
  - Stimulus: read_loc=0x100, write_loc=0x200, size=16; memory 0x100..0x10C = 0x11111111, 0x22222222, 0x33333333, 0x44444444; core returns blk_out XOR {4{0xFFFFFFFF}}.
  - Required: blk_out=0x11111111_22222222_33333333_44444444; writes to 0x200..0x20C = 0xEEEEEEEE, 0xDDDDDDDD, 0xCCCCCCCC, 0xBBBBBBBB; done pulses once; err=0.
- Wait states: slave holds hready=0 for 2 cycles on every phase, size=32 (2 blocks) -> haddr, htrans and hwdata stable during stalls; 8 reads and 8 writes in address order; done once.
- size=0 and size=15 -> no NONSEQ ever issued; done pulses 2 cycles after start; busy high for exactly 1 cycle.
- Error: hresp=1 on the third read data phase -> err=1, done pulses, no PUSH, no writes; next start clears err.
- Wrap and guard: read_loc=0xFFFFFFF8, size=16 -> read addresses FFFFFFF8, FFFFFFFC, 00000000, 00000004. A second start pulse while busy is ignored (one done only).
- Reset mid-transfer: hresetn=0 during WR_ADDR -> all outputs return to reset values within the same cycle; htrans=IDLE; no done.
